// File: rtl/data_mem.sv
// data_mem: byte-addressed data memory with valid/ready handshake, programmable latency and sub-word access
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
module data_mem #(
  parameter int N = 10,
  parameter int M = `DATA_WIDTH,
  parameter int ADR_WIDTH = `DATA_WIDTH,
  parameter int LATENCY = 1,
  parameter INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [ADR_WIDTH-1:0] req_adr,
  input  logic [M-1:0]         req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [M-1:0]         rsp_rdata,
  output logic                 rsp_err
);
  localparam int OB = (M == 64) ? 3 : 2;
  localparam int DEPTH = 1 << (N - OB);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [M-1:0] mem [DEPTH];
  logic [M-1:0] pend_data;
  logic pend_err;
  logic [N-OB-1:0] idx;
  logic [OB-1:0] off;
  logic [6:0] bits, shamt;
  logic [M-1:0] word, sh, left, zext, sext, ld, res, lowmask, bmask, wsh;
  logic signed [M-1:0] lefts;
  logic err, acc, unused_adr;
  assign idx = req_adr[N-1:OB];
  assign off = req_adr[OB-1:0];
  assign unused_adr = ^req_adr[ADR_WIDTH-1:N];
  assign bits = 7'd8 << req_size;
  assign shamt = 7'(M) - bits;
  assign err = ((off & ~({OB{1'b1}} << req_size)) != '0) || (M == 32 && req_size == 2'b11);
  assign word = mem[idx];
  assign sh = word >> {off, 3'b000};
  assign left = sh << shamt;
  assign lefts = left;
  assign zext = left >> shamt;
  assign sext = lefts >>> shamt;
  assign ld = req_unsigned ? zext : sext;
  assign res = (req_we || err) ? '0 : ld;
  assign lowmask = ~({M{1'b1}} << bits);
  assign bmask = lowmask << {off, 3'b000};
  assign wsh = req_wdata << {off, 3'b000};
  assign acc = req_valid && state == IDLE && !rst;
  initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  always @(posedge clk)
    if (acc && req_we && !err) mem[idx] <= (word & ~bmask) | (wsh & bmask);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      pend_data <= '0;
      pend_err <= 1'b0;
    end else
      case (state)
        IDLE: if (req_valid) begin
          pend_data <= res;
          pend_err <= err;
          req_ready <= 1'b0;
          cnt <= 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            state <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= res;
            rsp_err <= err;
          end else state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= pend_data;
            rsp_err <= pend_err;
          end
        end
        RESP: if (rsp_ready) begin
          state <= IDLE;
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          rsp_err <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: randomized bench for data_mem against a byte-array reference model
module tb_data_mem;
  localparam int M = 32, N = 10, LAT = 3;
  logic clk = 0, rst = 1, req_valid = 0, req_ready, req_we = 0, req_unsigned = 0;
  logic rsp_valid, rsp_ready = 0, rsp_err;
  logic [1:0] req_size = 0;
  logic [31:0] req_adr = 0, req_wdata = 0, rsp_rdata;
  data_mem #(.N(N), .M(M), .ADR_WIDTH(32), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_adr(req_adr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));
  always #5 clk = ~clk;
  typedef struct {logic [31:0] data; logic err; int acc;} exp_t;
  exp_t q[$];
  logic [7:0] mm [1024];
  int cyc = 0, total = 0, bad = 0, rdy_mode = 0;
  bit ready_m = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  // returns {err, data} the spec's rules demand for a request against the current byte image
  function automatic logic [32:0] model(logic we, logic [1:0] sz, logic uns, logic [31:0] adr);
    int n, a;
    logic [63:0] v;
    n = 1 << sz;
    a = int'(adr[9:0]);
    v = 0;
    if (sz == 2'd3 || (a % n) != 0) return {1'b1, 32'h0};
    if (we) return 33'h0;
    for (int i = 0; i < n; i++) v |= 64'(mm[(a + i) % 1024]) << (8 * i);
    if (!uns && n < 4 && v[8*n-1]) v |= {64{1'b1}} << (8 * n);
    return {1'b0, v[31:0]};
  endfunction
  always @(negedge clk) begin : cmp
    bit ev;
    if (rst) begin
      ready_m = 0;
      check("rst_valid", rsp_valid, 0);
      check("rst_rdata", rsp_rdata, 0);
      check("rst_err", rsp_err, 0);
    end else if (q.size() == 0) begin
      ready_m = 1;
      check("idle_ready", req_ready, 1);
      check("idle_valid", rsp_valid, 0);
    end else begin
      ready_m = 0;
      ev = (cyc - q[0].acc) >= LAT - 1;
      check("busy_ready", req_ready, 0);
      check("rsp_valid", rsp_valid, ev);
      if (ev) begin
        check("rsp_rdata", rsp_rdata, q[0].data);
        check("rsp_err", rsp_err, q[0].err);
        if (rsp_ready) void'(q.pop_front());
      end
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    rsp_ready = rdy_mode == 0 ? ($urandom_range(0, 2) != 0) : rdy_mode == 2;
  end
  task automatic issue(logic we, logic [1:0] sz, logic uns, logic [31:0] adr, logic [31:0] wd,
                       bit lit = 0, logic [32:0] want = 0);
    logic [32:0] e;
    bit ok;
    ok = 0;
    req_we = we; req_size = sz; req_unsigned = uns; req_adr = adr; req_wdata = wd; req_valid = 1;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(posedge clk);
      #1;
      ok = ready_m;
    end
    if (!ok) begin
      check("accept_timeout", 0, 1);
      req_valid = 0;
      return;
    end
    e = model(we, sz, uns, adr);
    if (lit) check("model_lit", e, want);
    q.push_back('{data: e[31:0], err: e[32], acc: cyc});
    if (we && !e[32])
      for (int i = 0; i < (1 << sz); i++) mm[(int'(adr[9:0]) + i) % 1024] = wd[8*i+:8];
    req_valid = 0;
    req_wdata = $urandom;
  endtask
  task automatic drain();
    for (int k = 0; k < 200 && q.size() != 0; k++) @(negedge clk);
    if (q.size() != 0) check("drain_timeout", q.size(), 0);
    @(posedge clk);
    #1;
  endtask
  task automatic mid_reset(int d);
    repeat (d) @(posedge clk);
    #2;
    rst = 1;
    q.delete();
    #1;
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_rdata", rsp_rdata, 0);
    check("mid_rst_err", rsp_err, 0);
    @(posedge clk);
    #1;
    rst = 0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] adr;
    logic [1:0] sz;
    for (int i = 0; i < 1024; i++) mm[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    issue(1, 2, 0, 32'h10, 32'hDEADBEEF, 1, 33'h0);
    issue(0, 2, 0, 32'h10, 0, 1, {1'b0, 32'hDEADBEEF});
    issue(0, 0, 0, 32'h13, 0, 1, {1'b0, 32'hFFFFFFDE});
    issue(0, 0, 1, 32'h13, 0, 1, {1'b0, 32'h000000DE});
    issue(0, 1, 0, 32'h12, 0, 1, {1'b0, 32'hFFFFDEAD});
    issue(0, 1, 1, 32'h12, 0, 1, {1'b0, 32'h0000DEAD});
    issue(0, 0, 0, 32'h10, 0, 1, {1'b0, 32'hFFFFFFEF});
    issue(1, 0, 0, 32'h11, 32'h000000AA, 1, 33'h0);
    issue(0, 2, 0, 32'h10, 0, 1, {1'b0, 32'hDEADAAEF});
    issue(1, 1, 0, 32'h12, 32'h00001234, 1, 33'h0);
    issue(0, 2, 0, 32'h10, 0, 1, {1'b0, 32'h1234AAEF});
    issue(0, 1, 0, 32'h11, 0, 1, {1'b1, 32'h0});
    issue(1, 2, 0, 32'h12, 32'hFFFFFFFF, 1, {1'b1, 32'h0});
    issue(0, 2, 0, 32'h10, 0, 1, {1'b0, 32'h1234AAEF});
    issue(0, 3, 0, 32'h10, 0, 1, {1'b1, 32'h0});
    issue(0, 2, 0, 32'h410, 0, 1, {1'b0, 32'h1234AAEF});
    drain();
    rdy_mode = 1; rsp_ready = 0;
    issue(0, 2, 0, 32'h10, 0, 1, {1'b0, 32'h1234AAEF});
    repeat (6) @(posedge clk);
    #1;
    rdy_mode = 2; rsp_ready = 1;
    issue(0, 0, 1, 32'h12, 0, 1, {1'b0, 32'h00000034});
    drain();
    rdy_mode = 1; rsp_ready = 0;
    issue(1, 2, 0, 32'h40, 32'hCAFEF00D, 1, 33'h0);
    mid_reset(1);
    rdy_mode = 2; rsp_ready = 1;
    issue(0, 2, 0, 32'h40, 0, 1, {1'b0, 32'hCAFEF00D});
    drain();
    rdy_mode = 1; rsp_ready = 0;
    issue(0, 0, 0, 32'h43, 0, 1, {1'b0, 32'hFFFFFFCA});
    mid_reset(2);
    repeat (5) @(posedge clk);
    #1;
    rdy_mode = 0;
    for (int t = 0; t < 200; t++) begin
      sz = 2'($urandom_range(0, 3));
      adr = $urandom_range(0, 127);
      if ($urandom_range(0, 4) != 0) adr &= ~((32'd1 << sz) - 32'd1);
      if ($urandom_range(0, 7) == 0) adr |= $urandom & ~32'h3FF;
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), adr, $urandom);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
